// File: rtl/usbh_hid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usbh_hid_pkg
// Description : Shared constants for the multi-channel HID report collector:
//               viewing-mode encodings, channel index width and the width of
//               the per-channel accepted-report counter.
// Revision    : 1.0 - initial release
// ============================================================================
package usbh_hid_pkg;

    // Viewing-mode encodings for C_mode.
    localparam int C_view_follow = 0;
    localparam int C_view_fixed  = 1;
    localparam int C_view_scan   = 2;

    // Channel index width (up to 8 channels).
    localparam int C_ch_width  = 3;

    // Width of the per-channel accepted-report counter.
    localparam int C_cnt_width = 8;

endpackage : usbh_hid_pkg
`default_nettype wire

// File: rtl/usbh_hid_chan_capture.sv
`default_nettype none
// ============================================================================
// Module      : usbh_hid_chan_capture
// Description : One HID channel: holding register with change-only filter,
//               accepted-report counter and staleness counter.
// Ports       : clk, reset_n      - clock, async active-low reset
//               report, valid     - report slice and its one-cycle strobe
//               held              - last accepted report
//               accept            - combinational: this cycle's valid is taken
//               count             - accepted reports, wraps 255 -> 0
//               stale             - no valid for C_stale_cycles cycles
// Revision    : 1.0 - initial release
// ============================================================================
module usbh_hid_chan_capture
    import usbh_hid_pkg::*;
#(
    parameter int C_report_length = 20,
    parameter int C_stale_cycles  = 600000,
    parameter int C_change_only   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [C_report_length*8-1:0] report,
    input  logic                         valid,
    output logic [C_report_length*8-1:0] held,
    output logic                         accept,
    output logic [C_cnt_width-1:0]       count,
    output logic                         stale
);

    localparam int                   c_stale_w   = $clog2(C_stale_cycles + 1);
    localparam logic [c_stale_w-1:0] c_stale_max = c_stale_w'(C_stale_cycles);
    localparam logic [c_stale_w-1:0] c_stale_one = c_stale_w'(1);
    localparam logic [C_cnt_width-1:0] c_cnt_one = C_cnt_width'(1);

    logic [C_report_length*8-1:0] r_held;
    logic                         r_ever;
    logic [C_cnt_width-1:0]       r_count;
    logic [c_stale_w-1:0]         r_stale_cnt;

    logic w_differs;
    logic w_accept;

    // The first report after reset is always taken, even if it is all zeros
    // and therefore matches the cleared holding register.
    assign w_differs = (report != r_held) || !r_ever;
    assign w_accept  = valid && ((C_change_only == 0) || w_differs);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_held      <= '0;
            r_ever      <= 1'b0;
            r_count     <= '0;
            r_stale_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_held  <= report;
                r_ever  <= 1'b1;
                r_count <= r_count + c_cnt_one;
            end
            // Any valid, duplicate or not, proves the device is alive.
            if (valid) begin
                r_stale_cnt <= '0;
            end else if (r_stale_cnt != c_stale_max) begin
                r_stale_cnt <= r_stale_cnt + c_stale_one;
            end
        end
    end

    assign held   = r_held;
    assign accept = w_accept;
    assign count  = r_count;
    assign stale  = (r_stale_cnt == c_stale_max);

endmodule : usbh_hid_chan_capture
`default_nettype wire

// File: rtl/usbh_hid_report_mux.sv
`default_nettype none
// ============================================================================
// Module      : usbh_hid_report_mux
// Description : Collects HID reports from several host channels and presents
//               the leading bytes of one channel as a display word. The viewed
//               channel is chosen by a fixed viewing mode: follow latest,
//               fixed select, or timed scan skipping stale channels.
// Ports       : clk, reset_n      - clock, async active-low reset
//               hid_report        - all channels' reports, channel k at
//                                   [k*L*8 +: L*8], byte 0 at the LSBs
//               hid_valid         - per-channel one-cycle report strobe
//               sel               - viewed channel in fixed mode
//               display           - bytes 0..D-1 of the viewed held report
//               display_ch        - viewed channel index
//               display_update    - pulse when display or display_ch changes
//               report_count      - per-channel accepted-report counters
//               stale             - per-channel staleness flags
// Revision    : 1.0 - initial release
// ============================================================================
module usbh_hid_report_mux
    import usbh_hid_pkg::*;
#(
    parameter int C_channels      = 3,
    parameter int C_report_length = 20,
    parameter int C_display_bytes = 8,
    parameter int C_mode          = 0,
    parameter int C_scan_cycles   = 6000000,
    parameter int C_stale_cycles  = 600000,
    parameter int C_change_only   = 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [C_channels*C_report_length*8-1:0] hid_report,
    input  logic [C_channels-1:0]                   hid_valid,
    input  logic [C_ch_width-1:0]                   sel,
    output logic [C_display_bytes*8-1:0]            display,
    output logic [C_ch_width-1:0]                   display_ch,
    output logic                                    display_update,
    output logic [C_channels*C_cnt_width-1:0]       report_count,
    output logic [C_channels-1:0]                   stale
);

    localparam int c_rep_w   = C_report_length * 8;
    localparam int c_disp_w  = C_display_bytes * 8;
    localparam int c_dwell_w = $clog2(C_scan_cycles);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(C_scan_cycles - 1);
    localparam logic [c_dwell_w-1:0] c_dwell_one  = c_dwell_w'(1);

    // View FSM encoding. The mode never changes after reset; the state only
    // selects which channel-selection rule is applied.
    localparam logic [1:0] c_st_follow = 2'd0;
    localparam logic [1:0] c_st_fixed  = 2'd1;
    localparam logic [1:0] c_st_scan   = 2'd2;
    localparam logic [1:0] c_st_reset  =
        (C_mode == C_view_fixed) ? c_st_fixed :
        (C_mode == C_view_scan)  ? c_st_scan  : c_st_follow;

    // ------------------------------------------------------------------------
    // Per-channel capture
    // ------------------------------------------------------------------------
    logic [c_rep_w-1:0]    w_held [C_channels];
    logic [C_channels-1:0] w_accept;
    logic [C_channels-1:0] w_stale;

    for (genvar k = 0; k < C_channels; k++) begin : g_chan
        usbh_hid_chan_capture #(
            .C_report_length (C_report_length),
            .C_stale_cycles  (C_stale_cycles),
            .C_change_only   (C_change_only)
        ) u_capture (
            .clk     (clk),
            .reset_n (reset_n),
            .report  (hid_report[k*c_rep_w +: c_rep_w]),
            .valid   (hid_valid[k]),
            .held    (w_held[k]),
            .accept  (w_accept[k]),
            .count   (report_count[k*C_cnt_width +: C_cnt_width]),
            .stale   (w_stale[k])
        );
    end

    assign stale = w_stale;

    // ------------------------------------------------------------------------
    // View FSM
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [C_ch_width-1:0] r_ch;
    logic [C_ch_width-1:0] w_ch_next;
    logic [c_dwell_w-1:0]  r_dwell;
    logic [c_dwell_w-1:0]  w_dwell_next;

    // Next non-stale channel after r_ch, searched cyclically in one cycle.
    // Candidates above r_ch take precedence over wrapped ones; among each
    // group the lowest index is the nearest.
    logic                  w_scan_hi;
    logic                  w_scan_lo;
    logic [C_ch_width-1:0] w_scan_hi_ch;
    logic [C_ch_width-1:0] w_scan_lo_ch;
    logic [C_ch_width-1:0] w_scan_ch;

    always_comb begin : p_scan_pick
        w_scan_hi    = 1'b0;
        w_scan_lo    = 1'b0;
        w_scan_hi_ch = '0;
        w_scan_lo_ch = '0;
        for (int k = C_channels - 1; k >= 0; k--) begin
            if (!w_stale[k]) begin
                if (C_ch_width'(k) > r_ch) begin
                    w_scan_hi    = 1'b1;
                    w_scan_hi_ch = C_ch_width'(k);
                end else begin
                    w_scan_lo    = 1'b1;
                    w_scan_lo_ch = C_ch_width'(k);
                end
            end
        end
        // All channels stale: stay where we are.
        w_scan_ch = w_scan_hi ? w_scan_hi_ch :
                    w_scan_lo ? w_scan_lo_ch : r_ch;
    end

    always_comb begin : p_view_next
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_dwell_next = r_dwell;
        case (r_state)
            c_st_follow: begin
                // Descending scan so the lowest accepting index wins.
                for (int k = C_channels - 1; k >= 0; k--) begin
                    if (w_accept[k]) begin
                        w_ch_next = C_ch_width'(k);
                    end
                end
            end
            c_st_fixed: begin
                w_ch_next = (int'(sel) < C_channels) ? sel : '0;
            end
            c_st_scan: begin
                if (r_dwell == c_dwell_last) begin
                    w_dwell_next = '0;
                    w_ch_next    = w_scan_ch;
                end else begin
                    w_dwell_next = r_dwell + c_dwell_one;
                end
            end
            default: begin
                w_state_next = c_st_reset;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_reset;
            r_ch    <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
            r_dwell <= w_dwell_next;
        end
    end

    // ------------------------------------------------------------------------
    // Display register
    // ------------------------------------------------------------------------
    logic [c_rep_w-1:0]    w_view_full;
    logic [c_disp_w-1:0]   w_view;
    logic [c_disp_w-1:0]   r_display;
    logic [C_ch_width-1:0] r_shown_ch;
    logic                  r_update;

    always_comb begin : p_view_mux
        w_view_full = '0;
        for (int k = 0; k < C_channels; k++) begin
            if (r_ch == C_ch_width'(k)) begin
                w_view_full = w_held[k];
            end
        end
    end

    assign w_view = w_view_full[c_disp_w-1:0];

    // Report bytes beyond the displayed window are not shown.
    if (c_disp_w < c_rep_w) begin : g_hidden_bytes
        logic w_unused_hidden;
        assign w_unused_hidden = ^w_view_full[c_rep_w-1:c_disp_w];
    end

    // r_shown_ch is the channel that r_display was taken from, so a channel
    // switch yields exactly one pulse, coincident with the new display word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_display  <= '0;
            r_shown_ch <= '0;
            r_update   <= 1'b0;
        end else begin
            r_display  <= w_view;
            r_shown_ch <= r_ch;
            r_update   <= (w_view != r_display) || (r_ch != r_shown_ch);
        end
    end

    assign display        = r_display;
    assign display_ch     = r_ch;
    assign display_update = r_update;

endmodule : usbh_hid_report_mux
`default_nettype wire

// File: tb/tb_usbh_hid_report_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_usbh_hid_report_mux
// Description : Self-checking bench for usbh_hid_report_mux. Three instances
//               share stimulus: follow-latest (scoreboarded display pulses),
//               fixed-select, and timed scan with small dwell/stale limits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usbh_hid_report_mux;

    localparam int c_ch  = 3;
    localparam int c_len = 20;
    localparam int c_rw  = c_len * 8;

    logic                  clk;
    logic                  reset_n;
    logic [c_ch*c_rw-1:0]  hid_report;
    logic [c_ch-1:0]       hid_valid;
    logic [2:0]            sel;

    logic [63:0]           f_disp, x_disp, s_disp;
    logic [2:0]            f_ch, x_ch, s_ch;
    logic                  f_upd, x_upd, s_upd;
    logic [c_ch*8-1:0]     f_cnt, x_cnt, s_cnt;
    logic [c_ch-1:0]       f_stale, x_stale, s_stale;

    int n_cmp = 0;
    int n_err = 0;
    int n_upd = 0;
    logic [71:0] sb_q[$];

    usbh_hid_report_mux #(.C_channels(c_ch), .C_report_length(c_len),
        .C_display_bytes(8), .C_mode(0)) u_follow (
        .clk(clk), .reset_n(reset_n), .hid_report(hid_report),
        .hid_valid(hid_valid), .sel(sel), .display(f_disp),
        .display_ch(f_ch), .display_update(f_upd),
        .report_count(f_cnt), .stale(f_stale));

    usbh_hid_report_mux #(.C_channels(c_ch), .C_report_length(c_len),
        .C_display_bytes(8), .C_mode(1)) u_fixed (
        .clk(clk), .reset_n(reset_n), .hid_report(hid_report),
        .hid_valid(hid_valid), .sel(sel), .display(x_disp),
        .display_ch(x_ch), .display_update(x_upd),
        .report_count(x_cnt), .stale(x_stale));

    usbh_hid_report_mux #(.C_channels(c_ch), .C_report_length(c_len),
        .C_display_bytes(8), .C_mode(2), .C_scan_cycles(16),
        .C_stale_cycles(40)) u_scan (
        .clk(clk), .reset_n(reset_n), .hid_report(hid_report),
        .hid_valid(hid_valid), .sel(sel), .display(s_disp),
        .display_ch(s_ch), .display_update(s_upd),
        .report_count(s_cnt), .stale(s_stale));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [71:0] obs,
                          input logic [71:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_report(input int ch, input logic [c_rw-1:0] r);
        hid_report[ch*c_rw +: c_rw] = r;
    endtask

    task automatic push_view(input logic [2:0] ch, input logic [c_rw-1:0] r);
        sb_q.push_back({5'b0, ch, r[63:0]});
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        hid_valid = '0;
        sb_q.delete();
        #20;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Scoreboard: every display pulse of the follow instance must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && f_upd) begin
            n_upd++;
            chk_eq("sb_has_entry", 72'(sb_q.size() > 0), 72'd1);
            if (sb_q.size() > 0) begin
                chk_eq("follow_view", {5'b0, f_ch, f_disp}, sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [c_rw-1:0] r;
        logic [c_rw-1:0] ra;
        logic [2:0]      prev;
        int              base;
        int              last;
        int              n_chg;
        bit              have_last;

        reset_n    = 1'b0;
        hid_report = '0;
        hid_valid  = '0;
        sel        = 3'd0;

        // ---- reset state ----
        do_reset();
        chk_eq("rst_display", 72'(f_disp), 72'd0);
        chk_eq("rst_display_ch", 72'(f_ch), 72'd0);
        chk_eq("rst_update", 72'(f_upd), 72'd0);
        chk_eq("rst_count", 72'(f_cnt), 72'd0);
        chk_eq("rst_stale", 72'(f_stale), 72'd0);

        // ---- single capture on channel 1 ----
        r = '0;
        r[63:0] = 64'h0807060504030201;
        set_report(1, r);
        base = n_upd;
        hid_valid = 3'b010;
        push_view(3'd1, r);
        tick();
        hid_valid = '0;
        repeat (4) tick();
        chk_eq("single_display", 72'(f_disp), 72'h0807060504030201);
        chk_eq("single_ch", 72'(f_ch), 72'd1);
        chk_eq("single_count1", 72'(f_cnt[15:8]), 72'd1);
        chk_eq("single_pulses", 72'(n_upd - base), 72'd1);

        // ---- change-only duplicate on channel 0 ----
        do_reset();
        base = n_upd;
        ra = '0;
        ra[63:0] = 64'h1122334455667788;
        set_report(0, ra);
        hid_valid = 3'b001;
        push_view(3'd0, ra);
        tick();
        hid_valid = '0;
        repeat (3) tick();
        hid_valid = 3'b001;
        tick();
        hid_valid = '0;
        repeat (3) tick();
        ra[63:0] = 64'h99AABBCCDDEEFF00;
        set_report(0, ra);
        hid_valid = 3'b001;
        push_view(3'd0, ra);
        tick();
        hid_valid = '0;
        repeat (4) tick();
        chk_eq("dup_count0", 72'(f_cnt[7:0]), 72'd2);
        chk_eq("dup_pulses", 72'(n_upd - base), 72'd2);
        chk_eq("dup_sb_empty", 72'(sb_q.size()), 72'd0);

        // ---- simultaneous valids on channels 0 and 2 ----
        sel = 3'd2;
        do_reset();
        r = '0;
        r[63:0] = 64'hA0A1A2A3A4A5A6A7;
        set_report(0, r);
        push_view(3'd0, r);
        r[63:0] = 64'hC0C1C2C3C4C5C6C7;
        set_report(2, r);
        hid_valid = 3'b101;
        tick();
        hid_valid = '0;
        repeat (4) tick();
        chk_eq("simul_ch", 72'(f_ch), 72'd0);
        chk_eq("simul_count0", 72'(f_cnt[7:0]), 72'd1);
        chk_eq("simul_count2", 72'(f_cnt[23:16]), 72'd1);
        chk_eq("simul_held2", 72'(x_disp), 72'hC0C1C2C3C4C5C6C7);
        chk_eq("simul_sb_empty", 72'(sb_q.size()), 72'd0);

        // ---- fixed select, out-of-range then valid channel ----
        sel = 3'd5;
        do_reset();
        repeat (3) tick();
        chk_eq("fixed_oor_ch", 72'(x_ch), 72'd0);
        r = '0;
        r[63:0] = 64'h5555AAAA1234F00D;
        set_report(2, r);
        hid_valid = 3'b100;
        push_view(3'd2, r);
        tick();
        hid_valid = '0;
        repeat (3) tick();
        chk_eq("fixed_oor_display", 72'(x_disp), 72'd0);
        sel = 3'd2;
        tick();
        chk_eq("fixed_ch_1edge", 72'(x_ch), 72'd2);
        chk_eq("fixed_upd_early", 72'(x_upd), 72'd0);
        tick();
        chk_eq("fixed_upd", 72'(x_upd), 72'd1);
        chk_eq("fixed_display", 72'(x_disp), 72'h5555AAAA1234F00D);
        tick();
        chk_eq("fixed_upd_single", 72'(x_upd), 72'd0);

        // ---- scan with a silent channel ----
        do_reset();
        r = '0;
        r[63:0] = 64'h0000000000000D00;
        set_report(0, r);
        push_view(3'd0, r);
        r[63:0] = 64'h0000000000000D02;
        set_report(2, r);
        prev      = s_ch;
        have_last = 1'b0;
        last      = 0;
        n_chg     = 0;
        for (int cyc = 0; cyc < 130; cyc++) begin
            hid_valid = ((cyc % 20) == 0) ? 3'b101 : 3'b000;
            tick();
            if (cyc == 50) begin
                chk_eq("scan_stale", 72'(s_stale), 72'b010);
            end
            if (s_ch != prev) begin
                if (cyc >= 44) begin
                    chk_eq("scan_next_ch", 72'(s_ch),
                           (prev == 3'd2) ? 72'd0 : 72'd2);
                    if (have_last) begin
                        chk_eq("scan_step", 72'(cyc - last), 72'd16);
                    end
                    have_last = 1'b1;
                    last      = cyc;
                    n_chg++;
                end
                prev = s_ch;
            end
        end
        hid_valid = '0;
        chk_eq("scan_changes_seen", 72'(n_chg >= 4), 72'd1);
        repeat (3) tick();
        chk_eq("scan_sb_empty", 72'(sb_q.size()), 72'd0);

        // ---- 256 back-to-back accepts on channel 1: counter wraps ----
        do_reset();
        r = '0;
        for (int i = 0; i < 256; i++) begin
            r[7:0]   = 8'(i);
            r[15:8]  = 8'hC3;
            r[63:56] = 8'h5A;
            set_report(1, r);
            hid_valid = 3'b010;
            push_view(3'd1, r);
            tick();
            if (i == 254) begin
                chk_eq("wrap_count255", 72'(f_cnt[15:8]), 72'd255);
            end
        end
        hid_valid = '0;
        repeat (4) tick();
        chk_eq("wrap_count0", 72'(f_cnt[15:8]), 72'd0);
        chk_eq("wrap_sb_empty", 72'(sb_q.size()), 72'd0);

        // ---- asynchronous reset mid-stream ----
        for (int i = 0; i < 4; i++) begin
            r[7:0] = 8'h40 + 8'(i);
            set_report(1, r);
            hid_valid = 3'b010;
            push_view(3'd1, r);
            tick();
        end
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        chk_eq("arst_display", 72'(f_disp), 72'd0);
        chk_eq("arst_ch", 72'(f_ch), 72'd0);
        chk_eq("arst_update", 72'(f_upd), 72'd0);
        chk_eq("arst_count", 72'(f_cnt), 72'd0);
        chk_eq("arst_stale", 72'(s_stale), 72'd0);
        hid_valid = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();
        chk_eq("arst_lost_display", 72'(f_disp), 72'd0);
        chk_eq("arst_lost_count", 72'(f_cnt), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_usbh_hid_report_mux
`default_nettype wire
